// File: rtl/aes_enc_iter.sv
// rtl/aes_enc_iter.sv - iterative AES-128 encryptor, one round per clock (optional block counter: AES_ENC_BLKCNT_EN)
module aes_enc_iter #(
    parameter int NR   = 10,
    parameter int KS_W = (NR + 1) * 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in,
    input  logic [KS_W-1:0]   word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out
`ifdef AES_ENC_BLKCNT_EN
    ,
    output logic [15:0]       blk_cnt
`endif
);

    localparam int         KW   = $clog2(KS_W);
    localparam logic [3:0] NR_L = 4'(NR);

    // Forward S-box, row-major: entry 0 occupies the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t            fsm, fsm_nxt;
    logic [3:0]      rnd;
    logic [127:0]    st;
    logic [127:0]    sb, sr, mc, round_out;
    logic [KW-1:0]   rk_hi;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    // One MixColumns column; top byte is row 0.
    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Round key for the round being computed sits at the top slice for rnd=0.
    assign rk_hi = KW'(KS_W - 1) - KW'({rnd, 7'b0});

    // Round datapath: SubBytes, ShiftRows, MixColumns (skipped on last round), AddRoundKey.
    always_comb begin
        sb        = '0;
        sr        = '0;
        mc        = '0;
        round_out = '0;
        for (int i = 0; i < 16; i++) begin
            sb[8*i +: 8] = sbox(st[8*i +: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127 - 32*c - 8*r -: 8] = sb[127 - 32*((c + r) % 4) - 8*r -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
        end
        round_out = ((rnd == NR_L) ? sr : mc) ^ word[rk_hi -: 128];
    end

    // State, round counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
            rnd <= 4'd0;
            st  <= '0;
            out <= '0;
        end else begin
            fsm <= fsm_nxt;
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        st  <= in ^ word[KS_W-1 -: 128];
                        rnd <= 4'd1;
                    end
                end
                ROUND: begin
                    st  <= round_out;
                    rnd <= rnd + 4'd1;
                    if (rnd == NR_L) begin
                        out <= round_out;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        fsm_nxt   = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_nxt = ROUND;
            end
            ROUND: begin
                if (rnd == NR_L) fsm_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

`ifdef AES_ENC_BLKCNT_EN
    // Count delivered ciphertext blocks; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= 16'd0;
        end else if (out_valid && out_ready) begin
            blk_cnt <= blk_cnt + 16'd1;
        end
    end
`endif

endmodule
